// File: rtl/mux8_rr_scheduler.sv
// ----------------------------------------------------------------------------
// mux8_rr_scheduler
// Round-robin scheduler that grants one of eight 1-bit requesters for a burst
// of up to MAXBURST beats and muxes the granted requester's data downstream.
//
// Ports
//   clk    in   1  system clock, all state changes on the rising edge
//   reset  in   1  asynchronous, active-high reset
//   req    in   8  req[i]: requester i has data to send
//   d      in   8  d[i]: 1-bit data of requester i
//   ready  in   1  downstream accepts a beat this cycle
//   s      out  3  current mux select (registered)
//   gnt    out  8  one-hot grant, zero when no grant (registered)
//   y      out  1  muxed data beat (combinational)
//   valid  out  1  y holds a valid beat (combinational)
// ----------------------------------------------------------------------------
module mux8_rr_scheduler #(
    parameter int unsigned MAXBURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [7:0] d,
    input  logic       ready,
    output logic [2:0] s,
    output logic [7:0] gnt,
    output logic       y,
    output logic       valid
);

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAXBURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   s_q, s_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   win_idx;
    logic [SEL_W-1:0]   scan_idx;

    // Beat output is combinational off the held select.
    assign valid = (state_q == BURST) && req[s_q];
    assign y     = valid && d[s_q];
    assign s     = s_q;
    assign gnt   = gnt_q;

    // Cyclic priority scan from ptr: walking backwards leaves the nearest
    // set request (smallest offset from ptr) as the final assignment.
    always_comb begin
        win_idx  = ptr_q;
        scan_idx = ptr_q;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = SEL_W'(ptr_q + SEL_W'(k));
            if (req[scan_idx]) begin
                win_idx = scan_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (req != '0) begin
                    state_d = BURST;
                    s_d     = win_idx;
                    gnt_d   = N_REQ'(1) << win_idx;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                // A dropped request or the last permitted transfer ends the
                // burst; s holds and the pointer moves past the winner.
                if (!req[s_q] || (ready && (cnt_q == CNT_LAST))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = SEL_W'(s_q + SEL_W'(1));
                end else if (ready) begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_mux8_rr_scheduler
// Drives two scheduler instances (MAXBURST=4 and MAXBURST=1) from shared
// inputs, compares both against a behavioural burst model every cycle, and
// runs directed scenarios with literal expectations before a random phase.
// ----------------------------------------------------------------------------
module tb_mux8_rr_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic [7:0] d;
    logic       ready;
    logic [2:0] s4, s1;
    logic [7:0] gnt4, gnt1;
    logic       y4, y1, valid4, valid1;

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mux8_rr_scheduler #(.MAXBURST(4)) u_mb4 (
        .clk(clk), .reset(reset), .req(req), .d(d), .ready(ready),
        .s(s4), .gnt(gnt4), .y(y4), .valid(valid4)
    );

    mux8_rr_scheduler #(.MAXBURST(1)) u_mb1 (
        .clk(clk), .reset(reset), .req(req), .d(d), .ready(ready),
        .s(s1), .gnt(gnt1), .y(y1), .valid(valid1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: per instance, whether a burst is in progress, who
    // owns it, how many beats have been accepted, and where the next scan starts.
    bit m_busy[2];
    int m_sel[2];
    int m_beats[2];
    int m_ptr[2];

    function automatic int max_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int first_from(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_busy[i]  <= 1'b0;
                m_sel[i]   <= 0;
                m_beats[i] <= 0;
                m_ptr[i]   <= 0;
            end else if (!m_busy[i]) begin
                if (req != 8'h00) begin
                    m_busy[i]  <= 1'b1;
                    m_sel[i]   <= first_from(req, m_ptr[i]);
                    m_beats[i] <= 0;
                end
            end else if (!req[m_sel[i]]) begin
                m_busy[i] <= 1'b0;
                m_ptr[i]  <= (m_sel[i] + 1) % 8;
            end else if (ready) begin
                m_beats[i] <= m_beats[i] + 1;
                if (m_beats[i] + 1 == max_of(i)) begin
                    m_busy[i] <= 1'b0;
                    m_ptr[i]  <= (m_sel[i] + 1) % 8;
                end
            end
        end
    end

    function automatic logic [7:0] exp_gnt(input int i);
        return m_busy[i] ? (8'(1) << m_sel[i]) : 8'h00;
    endfunction

    function automatic logic exp_valid(input int i);
        return m_busy[i] && req[m_sel[i]];
    endfunction

    function automatic logic exp_y(input int i);
        return exp_valid(i) && d[m_sel[i]];
    endfunction

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mb4_s",     32'(s4),     32'(m_sel[0]));
            chk("mb4_gnt",   32'(gnt4),   32'(exp_gnt(0)));
            chk("mb4_valid", 32'(valid4), 32'(exp_valid(0)));
            chk("mb4_y",     32'(y4),     32'(exp_y(0)));
            chk("mb1_s",     32'(s1),     32'(m_sel[1]));
            chk("mb1_gnt",   32'(gnt1),   32'(exp_gnt(1)));
            chk("mb1_valid", 32'(valid1), 32'(exp_valid(1)));
            chk("mb1_y",     32'(y1),     32'(exp_y(1)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves reset deasserted 1 time unit after an edge, in IDLE with ptr=0.
    task automatic do_reset();
        reset = 1'b1;
        req   = 8'h00;
        ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int q[$];
    int xfers;

    initial begin
        reset = 1'b1;
        req   = 8'h00;
        d     = 8'h00;
        ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        #3;
        chk("rst_s",     32'(s4),     32'd0);
        chk("rst_gnt",   32'(gnt4),   32'd0);
        chk("rst_valid", 32'(valid4), 32'd0);
        chk("rst_y",     32'(y4),     32'd0);

        // Single requester, full 4-beat burst, one idle cycle, re-grant.
        do_reset();
        req = 8'h01; d = 8'h01; ready = 1'b1;
        #3 chk("s30_idle_valid", 32'(valid4), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            #3;
            chk("s30_valid", 32'(valid4), 32'd1);
            chk("s30_y",     32'(y4),     32'd1);
            chk("s30_gnt",   32'(gnt4),   32'h01);
        end
        tick();
        #3;
        chk("s30_gap_valid", 32'(valid4), 32'd0);
        chk("s30_gap_gnt",   32'(gnt4),   32'h00);
        tick();
        #3;
        chk("s30_regrant", 32'(gnt4), 32'h01);

        // All requesting: rotate 0..7,0 with 4 beats each.
        do_reset();
        req = 8'hFF;
        q.delete();
        repeat (45) begin
            tick();
            d = 8'($urandom);
            #3;
            if (valid4) q.push_back(int'(s4));
        end
        chk("s31_len", 32'(q.size()), 32'd36);
        for (int k = 0; k < q.size() && k < 36; k++)
            chk("s31_seq", 32'(q[k]), 32'((k / 4) % 8));

        // MAXBURST=1 alternation between 0 and 7.
        do_reset();
        req = 8'h81;
        q.delete();
        repeat (8) begin
            tick();
            #3;
            if (valid1) q.push_back(int'(s1));
        end
        chk("s35_len", 32'(q.size()), 32'd4);
        for (int k = 0; k < q.size() && k < 4; k++)
            chk("s35_seq", 32'(q[k]), (k % 2 == 0) ? 32'd0 : 32'd7);

        // Stall on index 2 for three cycles mid-burst.
        do_reset();
        req = 8'h04; d = 8'h04; ready = 1'b1;
        tick();
        xfers = 0;
        for (int c = 0; c < 20; c++) begin
            ready = !(c >= 1 && c <= 3);
            d = 8'($urandom);
            #3;
            if (!valid4) break;
            chk("s32_s", 32'(s4), 32'd2);
            if (ready) xfers++;
            tick();
        end
        chk("s32_xfers", 32'(xfers), 32'd4);

        // Index 5 drops after two transfers; then 0x21 grants index 0.
        do_reset();
        req = 8'h20; d = 8'hFF; ready = 1'b1;
        tick();
        #3 chk("s33_s", 32'(s4), 32'd5);
        tick();
        tick();
        req = 8'h00;
        #3;
        chk("s33_drop_valid", 32'(valid4), 32'd0);
        chk("s33_drop_gnt",   32'(gnt4),   32'h20);
        tick();
        req = 8'h21;
        #3;
        chk("s33_idle_gnt",   32'(gnt4),   32'h00);
        chk("s33_idle_valid", 32'(valid4), 32'd0);
        tick();
        #3;
        chk("s33_next_s",   32'(s4),   32'd0);
        chk("s33_next_gnt", 32'(gnt4), 32'h01);

        // Reset mid-burst at s=3 clears outputs at once; scan restarts at 0.
        do_reset();
        req = 8'h08; ready = 1'b1; d = 8'hFF;
        repeat (7) tick();
        chk("s34_pre_s",     32'(s4),     32'd3);
        chk("s34_pre_valid", 32'(valid4), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("s34_async_s",     32'(s4),     32'd0);
        chk("s34_async_gnt",   32'(gnt4),   32'h00);
        chk("s34_async_valid", 32'(valid4), 32'd0);
        tick();
        reset = 1'b0;
        req = 8'h18;
        #3 chk("s34_idle_valid", 32'(valid4), 32'd0);
        tick();
        #3 chk("s34_rescan_s", 32'(s4), 32'd3);

        // Random traffic with occasional asynchronous resets.
        do_reset();
        repeat (3000) begin
            tick();
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0)
                req = ($urandom_range(0, 1) == 0) ? 8'($urandom & $urandom) : 8'($urandom);
            d     = 8'($urandom);
            ready = ($urandom_range(0, 3) != 0);
        end
        reset = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
